// File: rtl/serial_alu_pkg.sv
// ============================================================================
// serial_alu_pkg : op encodings, FSM states and carry-init helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_alu_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_ADC   = 3'b010;
   localparam logic [2:0] OP_SBB   = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_AND   = 3'b101;
   localparam logic [2:0] OP_OR    = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // SUB starts with carry=1 so that a + ~b + 1 forms two's-complement a - b
   function automatic logic carry_init(input logic [2:0] op, input logic cin);
      logic c;
      c = 1'b0;
      case (op)
         OP_SUB:         c = 1'b1;
         OP_ADC, OP_SBB: c = cin;
         default:        c = 1'b0;
      endcase
      return c;
   endfunction

   function automatic logic is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bit_slice.sv
// ============================================================================
// alu_bit_slice : one-bit combinational ALU datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_bit_slice
   import serial_alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] op,
   output logic       r,
   output logic       cout
);

   logic b_eff;

   always_comb begin
      b_eff = ((op == OP_SUB) || (op == OP_SBB)) ? ~b : b;
      r     = 1'b0;
      cout  = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
            r    = a ^ b_eff ^ cin;
            cout = (a & b_eff) | (cin & (a ^ b_eff));
         end
         OP_XOR:   r = a ^ b;
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_PASSB: r = b;
         default:  r = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/serial_alu_n.sv
// ============================================================================
// serial_alu_n : bit-serial LSB-first ALU with carry/zero/negative/overflow
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_alu_n
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] op,
   input  logic       carry_in,
   input  logic       bit_valid,
   input  logic       a_bit,
   input  logic       b_bit,
   output logic       r_valid,
   output logic       r_bit,
   output logic       busy,
   output logic       done,
   output logic       flag_c,
   output logic       flag_z,
   output logic       flag_n,
   output logic       flag_v
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  TERM = CW'(WIDTH - 1);

   state_t        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic          zacc_q, zacc_d;
   logic          r_valid_q, r_valid_d;
   logic          r_bit_q, r_bit_d;
   logic          done_q, done_d;
   logic          flag_c_q, flag_c_d;
   logic          flag_z_q, flag_z_d;
   logic          flag_n_q, flag_n_d;
   logic          flag_v_q, flag_v_d;
   logic          slice_r, slice_cout;

   alu_bit_slice u_slice (
      .a    (a_bit),
      .b    (b_bit),
      .cin  (carry_q),
      .op   (op_q),
      .r    (slice_r),
      .cout (slice_cout)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      zacc_d    = zacc_q;
      r_valid_d = 1'b0;
      r_bit_d   = r_bit_q;
      done_d    = 1'b0;
      flag_c_d  = flag_c_q;
      flag_z_d  = flag_z_q;
      flag_n_d  = flag_n_q;
      flag_v_d  = flag_v_q;
      case (state_q)
         // bit_valid in IDLE is dropped, including when it arrives with start
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               op_d    = op;
               cnt_d   = '0;
               zacc_d  = 1'b0;
               carry_d = carry_init(op, carry_in);
            end
         end
         S_RUN: begin
            if (bit_valid) begin
               r_valid_d = 1'b1;
               r_bit_d   = slice_r;
               carry_d   = slice_cout;
               zacc_d    = zacc_q | slice_r;
               if (cnt_q == TERM) begin
                  state_d  = S_IDLE;
                  done_d   = 1'b1;
                  flag_c_d = is_arith(op_q) & slice_cout;
                  flag_z_d = ~(zacc_q | slice_r);
                  flag_n_d = slice_r;
                  // carry_q is the carry into the MSB on the terminal bit
                  flag_v_d = is_arith(op_q) & (carry_q ^ slice_cout);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         zacc_q    <= 1'b0;
         r_valid_q <= 1'b0;
         r_bit_q   <= 1'b0;
         done_q    <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
         flag_v_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         zacc_q    <= zacc_d;
         r_valid_q <= r_valid_d;
         r_bit_q   <= r_bit_d;
         done_q    <= done_d;
         flag_c_q  <= flag_c_d;
         flag_z_q  <= flag_z_d;
         flag_n_q  <= flag_n_d;
         flag_v_q  <= flag_v_d;
      end
   end

   assign r_valid = r_valid_q;
   assign r_bit   = r_bit_q;
   assign busy    = (state_q == S_RUN);
   assign done    = done_q;
   assign flag_c  = flag_c_q;
   assign flag_z  = flag_z_q;
   assign flag_n  = flag_n_q;
   assign flag_v  = flag_v_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_n.sv
// ============================================================================
// tb_serial_alu_n : directed self-checking bench for serial_alu_n (WIDTH=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_alu_n;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = 3'b000;
   logic       carry_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       a_bit = 1'b0;
   logic       b_bit = 1'b0;
   logic       r_valid, r_bit, busy, done;
   logic       flag_c, flag_z, flag_n, flag_v;

   always #5 clk = ~clk;

   serial_alu_n #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .carry_in  (carry_in),
      .bit_valid (bit_valid),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .r_valid   (r_valid),
      .r_bit     (r_bit),
      .busy      (busy),
      .done      (done),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_v    (flag_v)
   );

   // output collector, sampled on the falling edge
   int         cyc = 0, nvalid = 0, ndone = 0, done_cyc = 0, done_nv = 0;
   logic [7:0] shreg = '0, done_res = '0;
   logic [3:0] done_flags = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (r_valid) begin
         shreg  = {r_bit, shreg[7:1]};
         nvalid = nvalid + 1;
      end
      if (done) begin
         ndone      = ndone + 1;
         done_cyc   = cyc;
         done_nv    = nvalid;
         done_res   = shreg;
         done_flags = {flag_c, flag_z, flag_n, flag_v};
      end
   end

   int checks = 0, passes = 0;
   int t0 = 0, nv0 = 0, nd0 = 0, stall_rv = 0, tmp = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Called just after a rising edge; start is driven together with a junk valid bit.
   task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input int stall_at, input int stall_len, input bit ign);
      t0 = cyc; nv0 = nvalid; nd0 = ndone; stall_rv = 0;
      start = 1'b1; op = o; carry_in = cin;
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = ~o; carry_in = ~cin;
      for (int i = 0; i < 8; i++) begin
         if (i == stall_at) begin
            bit_valid = 1'b0;
            repeat (stall_len) begin
               @(posedge clk); #1;
               if (r_valid) stall_rv++;
            end
         end
         bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
         if (ign && i == 3) begin
            start = 1'b1; op = 3'b111;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      bit_valid = 1'b0;
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   task automatic check_op(input string tag, input logic [7:0] res, input logic [3:0] cznv, input int lat);
      check({tag, " result"},  {24'd0, done_res},  {24'd0, res});
      check({tag, " cznv"},    {28'd0, done_flags}, {28'd0, cznv});
      check({tag, " ndone"},   ndone - nd0, 1);
      check({tag, " done@valid"}, done_nv - nv0, 8);
      check({tag, " latency"}, done_cyc - t0, lat);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", {24'd0, r_valid, r_bit, busy, done, flag_c, flag_z, flag_n, flag_v}, 32'd0);
      rst = 1'b0;
      settle();

      run_op(3'b000, 8'h7F, 8'h01, 1'b0, 99, 0, 1'b0);
      settle();
      check_op("ADD 7F+01", 8'h80, 4'b0011, 10);
      repeat (3) settle();
      check("flags hold", {28'd0, flag_c, flag_z, flag_n, flag_v}, {28'd0, 4'b0011});

      run_op(3'b001, 8'h05, 8'h05, 1'b0, 99, 0, 1'b0);
      settle();
      check_op("SUB 05-05", 8'h00, 4'b1100, 10);

      run_op(3'b010, 8'hFF, 8'h00, 1'b1, 99, 0, 1'b0);
      settle();
      check_op("ADC FF+00+1", 8'h00, 4'b1100, 10);

      tmp = nvalid;
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
      repeat (3) settle();
      bit_valid = 1'b0;
      check("idle bit_valid ignored", nvalid - tmp, 0);
      check("idle busy", {31'd0, busy}, 32'd0);

      run_op(3'b101, 8'hF0, 8'h3C, 1'b0, 99, 0, 1'b0);
      settle();
      check_op("AND F0&3C", 8'h30, 4'b0000, 10);

      run_op(3'b000, 8'h12, 8'h34, 1'b0, 4, 3, 1'b0);
      settle();
      check_op("stall ADD 12+34", 8'h46, 4'b0000, 13);
      check("stall r_valid gap", stall_rv, 0);

      run_op(3'b000, 8'h0F, 8'h01, 1'b0, 99, 0, 1'b1);
      settle();
      check_op("ignored start ADD 0F+01", 8'h10, 4'b0000, 10);
      repeat (12) settle();
      check("ignored start no extra op", ndone - nd0, 1);

      tmp = ndone;
      run_op(3'b110, 8'h0F, 8'hF0, 1'b0, 99, 0, 1'b0);
      run_op(3'b011, 8'h10, 8'h01, 1'b0, 99, 0, 1'b0);
      settle();
      check("b2b SBB result", {24'd0, done_res}, 32'h0E);
      check("b2b SBB cznv", {28'd0, done_flags}, {28'd0, 4'b1000});
      check("b2b ndone", ndone - tmp, 2);
      check("b2b latency", done_cyc - t0, 10);

      start = 1'b1; op = 3'b000; carry_in = 1'b0;
      settle();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
         settle();
      end
      bit_valid = 1'b0;
      check("pre-reset busy/valid/bit", {29'd0, busy, r_valid, r_bit}, 32'd7);
      tmp = ndone;
      rst = 1'b1;
      #1;
      check("mid-op reset outputs", {24'd0, r_valid, r_bit, busy, done, flag_c, flag_z, flag_n, flag_v}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) settle();
      check("mid-op reset no done", ndone - tmp, 0);

      run_op(3'b100, 8'hAA, 8'hFF, 1'b0, 99, 0, 1'b0);
      settle();
      check_op("XOR AA^FF", 8'h55, 4'b0000, 10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
